// File: rtl/rx_pkt_reader.sv
// -----------------------------------------------------------------------------
// rx_pkt_reader
//   Drains received packets out of the RX payload RAM. One {start addr, size}
//   descriptor is popped from a show-ahead descriptor FIFO. The controller then
//   issues 1-cycle-latency RAM reads with wrap-around addressing. The returned
//   bytes go out on a valid/ready stream with a last flag. A 2-entry skid buffer,
//   together with read credit, keeps every byte safe under any backpressure.
//
//   Optional feature macro: RX_PKT_READER_GAP_EN
//     defined   -> a GAP state of GAP_CYCLES idle cycles follows each packet
//     undefined -> DRAIN returns straight to IDLE (GAP_CYCLES does not exist)
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   desc_empty_in           descriptor FIFO empty
//   desc_addr_in/size_in    head descriptor (start address, byte count)
//   desc_rd_en              descriptor pop, 1-cycle pulse
//   mem_rd_en/mem_rd_addr   RAM read strobe and address
//   mem_rd_data_in          RAM data, valid the cycle after mem_rd_en
//   m_data/m_valid/m_last   output stream, m_last qualified by m_valid
//   m_ready_in              downstream ready
//   busy                    controller not in IDLE
//   stat_pkt_out_cnt        delivered packets, saturating at MAX_PACKET_CNT_VAL
// -----------------------------------------------------------------------------
module rx_pkt_reader #(
  parameter int ADDR_WIDTH         = 8,
  parameter int DATA_WIDTH         = 8,
  parameter int G_MEM_SIZE         = 256,
  parameter int MAX_PACKET_CNT_VAL = 20
`ifdef RX_PKT_READER_GAP_EN
  ,
  parameter int GAP_CYCLES         = 4
`endif
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  desc_empty_in,
  input  logic [ADDR_WIDTH-1:0] desc_addr_in,
  input  logic [7:0]            desc_size_in,
  output logic                  desc_rd_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_in,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready_in,
  output logic                  busy,
  output logic [15:0]           stat_pkt_out_cnt
);

`ifdef RX_PKT_READER_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_GAP} state_t;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;
`endif

  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    if (a == ADDR_WIDTH'(G_MEM_SIZE - 1)) return '0;
    return a + ADDR_WIDTH'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    if (c >= 16'(MAX_PACKET_CNT_VAL)) return c;
    return c + 16'd1;
  endfunction

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [7:0]            remaining;
  logic                  vld_p1;
  logic                  last_p1;
  logic [DATA_WIDTH-1:0] skid_data [2];
  logic [1:0]            skid_last;
  logic [1:0]            occ;
  logic                  head;
  logic                  credit_ok;
  logic                  hs;
  logic                  skid_push;
  logic                  skid_pop;
  logic                  wr_idx;
  logic                  pkt_done;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
`ifdef RX_PKT_READER_GAP_EN
  logic [GAP_W-1:0]      gap_cnt;
  logic                  gap_done;

  assign gap_done = (gap_cnt == GAP_W'(GAP_CYCLES - 1));
`endif

  // Every issued read owns a skid slot until it is consumed. The returning
  // beat (vld_p1) counts as occupied, so 2 outstanding items is the ceiling.
  assign credit_ok = (({1'b0, occ} + {2'b00, vld_p1}) < 3'd2);

  // Stage p1 -> stream: an empty skid forwards the returning RAM word
  // directly, so the first byte appears one cycle after its read.
  assign head_data = (occ != 2'd0) ? skid_data[head] : mem_rd_data_in;
  assign head_last = (occ != 2'd0) ? skid_last[head] : last_p1;
  assign m_valid   = (occ != 2'd0) | vld_p1;
  assign m_data    = m_valid ? head_data : '0;
  assign m_last    = m_valid & head_last;
  assign hs        = m_valid & m_ready_in;
  assign pkt_done  = (state == S_DRAIN) & hs & m_last;

  // A returning word enters the skid unless it leaves through the bypass.
  assign skid_pop  = hs & (occ != 2'd0);
  assign skid_push = vld_p1 & ~(hs & (occ == 2'd0));
  assign wr_idx    = head ^ occ[0];

  assign busy        = (state != S_IDLE);
  assign mem_rd_addr = mem_rd_en ? rd_ptr : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (desc_rd_en && desc_size_in != 8'd0) state_nx = S_STREAM;
      S_STREAM: if (mem_rd_en && remaining == 8'd1)     state_nx = S_DRAIN;
`ifdef RX_PKT_READER_GAP_EN
      S_DRAIN:  if (pkt_done) state_nx = S_GAP;
      S_GAP:    if (gap_done) state_nx = S_IDLE;
`else
      S_DRAIN:  if (pkt_done) state_nx = S_IDLE;
`endif
      default:  state_nx = S_IDLE;
    endcase
  end

  // Pops and reads are suppressed during reset. A descriptor taken then would
  // otherwise be lost without ever being streamed.
  always_comb begin
    desc_rd_en = 1'b0;
    mem_rd_en  = 1'b0;
    case (state)
      S_IDLE:   desc_rd_en = ~desc_empty_in & ~rst_in;
      S_STREAM: mem_rd_en  = credit_ok & ~rst_in;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p1           <= 1'b0;
      occ              <= 2'd0;
      head             <= 1'b0;
      stat_pkt_out_cnt <= 16'd0;
`ifdef RX_PKT_READER_GAP_EN
      gap_cnt          <= '0;
`endif
    end else begin
      vld_p1 <= mem_rd_en;
      occ    <= occ + {1'b0, skid_push} - {1'b0, skid_pop};
      if (skid_pop) head <= ~head;
      if (pkt_done) stat_pkt_out_cnt <= sat_inc(stat_pkt_out_cnt);
`ifdef RX_PKT_READER_GAP_EN
      if (state == S_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
      else                gap_cnt <= '0;
`endif
    end
  end

  // Stage p0 -> p1: the read address is issued, and the last flag follows the read.
  always_ff @(posedge clk_in) begin
    if (desc_rd_en) begin
      rd_ptr    <= desc_addr_in;
      remaining <= desc_size_in;
    end else if (mem_rd_en) begin
      rd_ptr    <= wrap_inc(rd_ptr);
      remaining <= remaining - 8'd1;
    end
    last_p1 <= mem_rd_en & (remaining == 8'd1);
    if (skid_push) begin
      skid_data[wr_idx] <= mem_rd_data_in;
      skid_last[wr_idx] <= last_p1;
    end
  end

endmodule

// File: tb/tb_rx_pkt_reader.sv
// -----------------------------------------------------------------------------
// tb_rx_pkt_reader
//   Directed and randomized bench for rx_pkt_reader. The bench supplies a RAM
//   model with random contents and a show-ahead descriptor FIFO. Each pushed
//   descriptor expands into the expected read-address list and the expected byte
//   list. A negedge monitor logs pops, reads and handshakes. The main sequence
//   compares the logs against the expectations.
// -----------------------------------------------------------------------------
module tb_rx_pkt_reader;

`ifdef RX_PKT_READER_GAP_EN
  localparam int SPACING = 5;
`else
  localparam int SPACING = 1;
`endif
  localparam int MAX_CNT = 20;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        desc_empty_in;
  logic [7:0]  desc_addr_in;
  logic [7:0]  desc_size_in;
  logic        desc_rd_en;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_addr;
  logic [7:0]  mem_rd_data_in;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready_in;
  logic        busy;
  logic [15:0] stat_pkt_out_cnt;

  rx_pkt_reader dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .desc_empty_in    (desc_empty_in),
    .desc_addr_in     (desc_addr_in),
    .desc_size_in     (desc_size_in),
    .desc_rd_en       (desc_rd_en),
    .mem_rd_en        (mem_rd_en),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_data_in   (mem_rd_data_in),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_last           (m_last),
    .m_ready_in       (m_ready_in),
    .busy             (busy),
    .stat_pkt_out_cnt (stat_pkt_out_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Payload RAM with a 1-cycle read latency
  logic [7:0] mem [256];
  always @(posedge clk_in) if (mem_rd_en) mem_rd_data_in <= mem[mem_rd_addr];

  // Show-ahead descriptor FIFO
  logic [7:0] d_addr [128];
  logic [7:0] d_size [128];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign desc_empty_in = (rd_cnt == wr_cnt);
  assign desc_addr_in  = d_addr[rd_cnt[6:0]];
  assign desc_size_in  = d_size[rd_cnt[6:0]];
  always @(posedge clk_in) if (desc_rd_en) rd_cnt <= rd_cnt + 1;

  // Monitor logs
  int         cyc = 0;
  int         pop_cyc_q[$];
  logic [7:0] rd_addr_q[$];
  int         rd_cyc_q[$];
  logic [8:0] beat_q[$];
  int         beat_cyc_q[$];
  int         proto_viol = 0;
  int         stab_viol = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;

  always @(negedge clk_in) begin
    cyc <= cyc + 1;
    if (desc_rd_en) begin
      pop_cyc_q.push_back(cyc);
      if (desc_empty_in || busy) proto_viol <= proto_viol + 1;
    end
    if (mem_rd_en) begin
      rd_addr_q.push_back(mem_rd_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (m_valid && m_ready_in) begin
      beat_q.push_back({m_last, m_data});
      beat_cyc_q.push_back(cyc);
    end
    if (rst_in) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        stab_viol <= stab_viol + 1;
      prev_stall <= m_valid && !m_ready_in;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end
  end

  // Reference model: expected read addresses and beats, plus a packet count
  logic [7:0] exp_addr_q[$];
  logic [8:0] exp_beat_q[$];
  int pkts_valid = 0;
  int nr_chk = 0, ner_chk = 0, nb_chk = 0, ne_chk = 0;

  int n_cmp = 0;
  int n_fail = 0;
  int p0, r0, b0, pc, rc, bc, lastn, total, kk, rr, sz;

  function automatic int exp_cnt();
    return (pkts_valid > MAX_CNT) ? MAX_CNT : pkts_valid;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_desc(input logic [7:0] addr, input logic [7:0] size);
    d_addr[wr_cnt[6:0]] = addr;
    d_size[wr_cnt[6:0]] = size;
    wr_cnt++;
    for (int i = 0; i < int'(size); i++) begin
      int a;
      a = (int'(addr) + i) % 256;
      exp_addr_q.push_back(8'(a));
      exp_beat_q.push_back({1'(i == int'(size) - 1), mem[a]});
    end
    if (size != 8'd0) pkts_valid++;
  endtask

  task automatic drive_ready(input bit rnd, input int k, input int stall_lo);
    if (stall_lo >= 0 && k >= stall_lo && k < stall_lo + 10) m_ready_in = 1'b0;
    else if (rnd) m_ready_in = 1'($urandom_range(0, 1));
    else m_ready_in = 1'b1;
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget,
                            input bit rnd, input int stall_lo);
    int k = 0;
    drive_ready(rnd, 0, stall_lo);
    while (beat_q.size() < target && k < budget) begin
      tick();
      k++;
      drive_ready(rnd, k, stall_lo);
    end
    chk({tag, "_beats_done"}, 32'(beat_q.size()), 32'(target));
    m_ready_in = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic check_reads(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_rd_addr"}, 32'(rd_addr_q[nr_chk]), 32'(exp_addr_q[ner_chk]));
      nr_chk++;
      ner_chk++;
    end
  endtask

  task automatic check_beats(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_beat"}, 32'(beat_q[nb_chk]), 32'(exp_beat_q[ne_chk]));
      nb_chk++;
      ne_chk++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    m_ready_in = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (3) tick();
    rst_in = 1'b0;

    // Reset state
    chk("rst_desc_rd_en", 32'(desc_rd_en), 32'(0));
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
    chk("rst_mem_rd_addr", 32'(mem_rd_addr), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_last", 32'(m_last), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cnt", 32'(stat_pkt_out_cnt), 32'(0));
    tick();

    // Single packet: addr 0x10, size 8, ready held high
    p0 = pop_cyc_q.size(); r0 = rd_addr_q.size(); b0 = beat_q.size();
    push_desc(8'h10, 8'd8);
    wait_beats("t1", b0 + 8, 100, 1'b0, -1);
    wait_idle("t1", 50);
    pc = pop_cyc_q[p0];
    for (int i = 0; i < 8; i++) begin
      chk("t1_rd_cyc", 32'(rd_cyc_q[r0 + i]), 32'(pc + 1 + i));
      chk("t1_beat_cyc", 32'(beat_cyc_q[b0 + i]), 32'(pc + 2 + i));
    end
    check_reads("t1", 8);
    check_beats("t1", 8);
    chk("t1_cnt", 32'(stat_pkt_out_cnt), 32'(exp_cnt()));

    // Wrap: addr 0xFE, size 8
    r0 = rd_addr_q.size(); b0 = beat_q.size();
    push_desc(8'hFE, 8'd8);
    wait_beats("t2", b0 + 8, 100, 1'b0, -1);
    wait_idle("t2", 50);
    chk("t2_wrap_addr", 32'(rd_addr_q[r0 + 2]), 32'h00);
    check_reads("t2", 8);
    check_beats("t2", 8);
    chk("t2_cnt", 32'(stat_pkt_out_cnt), 32'(exp_cnt()));

    // Backpressure: size 12, random ready plus a 10-cycle stall
    b0 = beat_q.size();
    push_desc(8'($urandom), 8'd12);
    wait_beats("t3", b0 + 12, 300, 1'b1, 3);
    wait_idle("t3", 50);
    check_reads("t3", 12);
    check_beats("t3", 12);
    chk("t3_stable", 32'(stab_viol), 32'(0));
    chk("t3_cnt", 32'(stat_pkt_out_cnt), 32'(exp_cnt()));

    // Back-to-back: three descriptors of 8/9/10 bytes queued together
    p0 = pop_cyc_q.size(); b0 = beat_q.size();
    push_desc(8'($urandom), 8'd8);
    push_desc(8'($urandom), 8'd9);
    push_desc(8'($urandom), 8'd10);
    wait_beats("t4", b0 + 27, 300, 1'b0, -1);
    wait_idle("t4", 50);
    lastn = 0;
    for (int i = 0; i < 27; i++) lastn += int'(beat_q[b0 + i][8]);
    chk("t4_last_pulses", 32'(lastn), 32'(3));
    chk("t4_gap01", 32'(pop_cyc_q[p0 + 1] - beat_cyc_q[b0 + 7]), 32'(SPACING));
    chk("t4_gap12", 32'(pop_cyc_q[p0 + 2] - beat_cyc_q[b0 + 16]), 32'(SPACING));
    check_reads("t4", 27);
    check_beats("t4", 27);
    chk("t4_cnt", 32'(stat_pkt_out_cnt), 32'(exp_cnt()));

    // Zero-size descriptor: popped, no reads, no beats, no count change
    p0 = pop_cyc_q.size(); r0 = rd_addr_q.size(); b0 = beat_q.size();
    push_desc(8'($urandom), 8'd0);
    repeat (6) tick();
    chk("t5_zero_pop", 32'(pop_cyc_q.size()), 32'(p0 + 1));
    chk("t5_zero_reads", 32'(rd_addr_q.size()), 32'(r0));
    chk("t5_zero_beats", 32'(beat_q.size()), 32'(b0));
    chk("t5_zero_busy", 32'(busy), 32'(0));
    chk("t5_zero_cnt", 32'(stat_pkt_out_cnt), 32'(exp_cnt()));

    // Saturation: 25 random packets under random ready
    total = 0;
    for (int i = 0; i < 25; i++) begin
      sz = $urandom_range(1, 8);
      total += sz;
      push_desc(8'($urandom), 8'(sz));
    end
    wait_beats("t5", b0 + total, 4000, 1'b1, -1);
    wait_idle("t5", 50);
    check_reads("t5", total);
    check_beats("t5", total);
    chk("t5_sat_cnt", 32'(stat_pkt_out_cnt), 32'(MAX_CNT));

    // Reset in the middle of a 10-byte packet
    b0 = beat_q.size();
    push_desc(8'($urandom), 8'd10);
    wait_beats("t6", b0 + 3, 50, 1'b0, -1);
    rst_in = 1'b1;
    rc = rd_addr_q.size();
    tick();
    rst_in = 1'b0;
    chk("t6_rst_m_valid", 32'(m_valid), 32'(0));
    chk("t6_rst_m_data", 32'(m_data), 32'(0));
    chk("t6_rst_m_last", 32'(m_last), 32'(0));
    chk("t6_rst_mem_rd_en", 32'(mem_rd_en), 32'(0));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    chk("t6_rst_cnt", 32'(stat_pkt_out_cnt), 32'(0));
    bc = beat_q.size();
    repeat (10) tick();
    chk("t6_no_more_reads", 32'(rd_addr_q.size()), 32'(rc));
    chk("t6_no_more_beats", 32'(beat_q.size()), 32'(bc));
    rr = rc - nr_chk;
    check_reads("t6_abort", rr);
    ner_chk += 10 - rr;
    kk = bc - nb_chk;
    check_beats("t6_abort", kk);
    ne_chk += 10 - kk;
    pkts_valid = 0;

    // The next descriptor streams from its own address
    b0 = beat_q.size();
    push_desc(8'($urandom), 8'd5);
    wait_beats("t7", b0 + 5, 100, 1'b0, -1);
    wait_idle("t7", 50);
    check_reads("t7", 5);
    check_beats("t7", 5);
    chk("t7_cnt", 32'(stat_pkt_out_cnt), 32'(exp_cnt()));

    // Global protocol properties and absence of stray traffic
    repeat (5) tick();
    chk("proto_pop", 32'(proto_viol), 32'(0));
    chk("stable_hold", 32'(stab_viol), 32'(0));
    chk("extra_reads", 32'(rd_addr_q.size()), 32'(nr_chk));
    chk("extra_beats", 32'(beat_q.size()), 32'(nb_chk));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
